// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - core-to-bus memory arbiter: data access then fetch, lane alignment, load extension
// Optional ack watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inst_rd_en,
  input  logic [DATA_SIZE-1:0]   inst_mem_addr,
  output logic [31:0]            inst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_SIZE-1:0]   data_mem_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  input  logic [DATA_SIZE/8-1:0] mem_byte_en,
  input  logic                   mem_signed,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   mem_busy,
  output logic                   bus_cyc,
  output logic                   bus_stb,
  output logic                   bus_we,
  output logic [DATA_SIZE-1:0]   bus_addr,
  output logic [DATA_SIZE/8-1:0] bus_sel,
  output logic [DATA_SIZE-1:0]   bus_dat_o,
  input  logic [DATA_SIZE-1:0]   bus_dat_i,
  input  logic                   bus_ack,
  output logic                   bus_err
);

  localparam int BE_W  = DATA_SIZE / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FETCH, ST_DONE} state_t;

  state_t state, state_next;

  logic             start_data, start_fetch, end_bus;
  logic             cap_load, cap_inst, abort_load, abort_inst;
  logic             timeout;
  logic [OFF_W-1:0] off;
  logic [DATA_SIZE-1:0] data_word_addr, inst_word_addr;
  logic [DATA_SIZE-1:0] shifted, load_result;
  logic             sign;
  logic [31:0]      fetch_word;

  assign off            = data_mem_addr[OFF_W-1:0];
  assign data_word_addr = {data_mem_addr[DATA_SIZE-1:OFF_W], {OFF_W{1'b0}}};
  assign inst_word_addr = {inst_mem_addr[DATA_SIZE-1:OFF_W], {OFF_W{1'b0}}};

  if (DATA_SIZE == 64) begin : g_fetch64
    assign fetch_word = inst_mem_addr[2] ? bus_dat_i[63:32] : bus_dat_i[31:0];
  end else begin : g_fetch32
    assign fetch_word = bus_dat_i[31:0];
  end

  // Bytes above the access are filled with the sign of its top byte (or zero).
  always_comb begin
    shifted     = bus_dat_i >> {off, 3'b000};
    sign        = 1'b0;
    load_result = '0;
    for (int i = 0; i < BE_W; i++) begin
      if (mem_byte_en[i]) begin
        load_result[8*i +: 8] = shifted[8*i +: 8];
        sign                  = mem_signed & shifted[8*i+7];
      end else begin
        load_result[8*i +: 8] = {8{sign}};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_busy    = 1'b0;
    start_data  = 1'b0;
    start_fetch = 1'b0;
    end_bus     = 1'b0;
    cap_load    = 1'b0;
    cap_inst    = 1'b0;
    abort_load  = 1'b0;
    abort_inst  = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_busy = inst_rd_en | rd_en | wr_en;
        if (rd_en | wr_en) begin
          state_next = ST_DATA;
          start_data = 1'b1;
        end else if (inst_rd_en) begin
          state_next  = ST_FETCH;
          start_fetch = 1'b1;
        end
      end
      ST_DATA: begin
        mem_busy = 1'b1;
        if (bus_ack) begin
          cap_load = ~wr_en;
          if (inst_rd_en) begin
            state_next  = ST_FETCH;
            start_fetch = 1'b1;
          end else begin
            state_next = ST_DONE;
            end_bus    = 1'b1;
          end
        end else if (timeout) begin
          abort_load = ~wr_en;
          state_next = ST_DONE;
          end_bus    = 1'b1;
        end
      end
      ST_FETCH: begin
        mem_busy = 1'b1;
        if (bus_ack) begin
          cap_inst   = 1'b1;
          state_next = ST_DONE;
          end_bus    = 1'b1;
        end else if (timeout) begin
          abort_inst = 1'b1;
          state_next = ST_DONE;
          end_bus    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus signals are registered; cyc stays high across a data-to-fetch handoff.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_cyc   <= 1'b0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_dat_o <= '0;
    end else if (start_data) begin
      bus_cyc   <= 1'b1;
      bus_stb   <= 1'b1;
      bus_we    <= wr_en;
      bus_addr  <= data_word_addr;
      bus_sel   <= mem_byte_en << off;
      bus_dat_o <= wr_data << {off, 3'b000};
    end else if (start_fetch) begin
      bus_cyc   <= 1'b1;
      bus_stb   <= 1'b1;
      bus_we    <= 1'b0;
      bus_addr  <= inst_word_addr;
      bus_sel   <= '1;
      bus_dat_o <= '0;
    end else if (end_bus) begin
      bus_cyc <= 1'b0;
      bus_stb <= 1'b0;
      bus_we  <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inst    <= 32'h0000_0013;
      rd_data <= '0;
    end else begin
      if (cap_load)        rd_data <= load_result;
      else if (abort_load) rd_data <= '0;
      if (cap_inst)        inst <= fetch_word;
      else if (abort_inst) inst <= '0;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_data || start_fetch)
        wd_cnt <= '0;
      else if (state == ST_DATA || state == ST_FETCH)
        wd_cnt <= wd_cnt + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign timeout = (state == ST_DATA || state == ST_FETCH) && !bus_ack &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a wait-state bus slave
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_rd_en, rd_en, wr_en, mem_signed;
  logic [31:0] inst_mem_addr, data_mem_addr, wr_data;
  logic [3:0]  mem_byte_en;
  logic [31:0] inst, rd_data;
  logic        mem_busy, bus_cyc, bus_stb, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_dat_o, bus_dat_i;
  logic [3:0]  bus_sel;

  mem_arbiter #(.DATA_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .inst_rd_en(inst_rd_en), .inst_mem_addr(inst_mem_addr), .inst(inst),
    .rd_en(rd_en), .wr_en(wr_en), .data_mem_addr(data_mem_addr), .wr_data(wr_data),
    .mem_byte_en(mem_byte_en), .mem_signed(mem_signed), .rd_data(rd_data),
    .mem_busy(mem_busy), .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_dat_o(bus_dat_o),
    .bus_dat_i(bus_dat_i), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  // Slave: acks after 'waits' stalled cycles; returns the fetch word at the fetch address.
  logic        slave_en, force_ack;
  int          waits, wcnt;
  logic [31:0] s_iaddr, s_iword, s_dword;

  always @(posedge clock) begin
    if (!bus_stb || bus_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end
  assign bus_ack   = force_ack | (slave_en & bus_stb & (wcnt >= waits));
  assign bus_dat_i = (bus_addr == s_iaddr) ? s_iword : s_dword;

  typedef struct {
    logic        f, r, w, sgn;
    logic [31:0] ia, iw, da, wd, dw;
    logic [3:0]  be;
    int          nw;
    logic [31:0] exp_inst, exp_rd;
    int          exp_busy, exp_stb, exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dato;
  } vec_t;

  vec_t vecs[$];
  int checks = 0, failures = 0;

  int          o_busy, o_stb, o_cyc, o_we, o_ichg;
  logic        o_done, o_seen;
  logic [31:0] o_addr, o_dato;
  logic [3:0]  o_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic f, r, w, sgn, input logic [31:0] ia, iw, da, wd, dw,
                              input logic [3:0] be, input int nw, input logic [31:0] ei, er,
                              input int eb, es, ew, input logic [31:0] ea, input logic [3:0] esel,
                              input logic [31:0] edo);
    vec_t v;
    v.f = f; v.r = r; v.w = w; v.sgn = sgn; v.ia = ia; v.iw = iw; v.da = da; v.wd = wd;
    v.dw = dw; v.be = be; v.nw = nw; v.exp_inst = ei; v.exp_rd = er; v.exp_busy = eb;
    v.exp_stb = es; v.exp_we = ew; v.exp_addr = ea; v.exp_sel = esel; v.exp_dato = edo;
    vecs.push_back(v);
  endfunction

  task automatic do_step(input vec_t v);
    logic [31:0] prev;
    @(posedge clock); #1;
    inst_rd_en = v.f; rd_en = v.r; wr_en = v.w; mem_signed = v.sgn;
    inst_mem_addr = v.ia; data_mem_addr = v.da; wr_data = v.wd; mem_byte_en = v.be;
    s_iaddr = v.ia; s_iword = v.iw; s_dword = v.dw; waits = v.nw;
    o_busy = 0; o_stb = 0; o_cyc = 0; o_we = 0; o_ichg = 0; o_done = 1'b0; o_seen = 1'b0;
    o_addr = '0; o_sel = '0; o_dato = '0;
    prev = inst;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (inst !== prev) begin o_ichg++; prev = inst; end
      if (!mem_busy) begin o_done = 1'b1; break; end
      o_busy++;
      if (bus_cyc) o_cyc++;
      if (bus_stb) begin
        if (!o_seen) begin o_addr = bus_addr; o_sel = bus_sel; o_dato = bus_dat_o; o_seen = 1'b1; end
        o_stb++;
        if (bus_we) o_we++;
      end
    end
    chk("step_completes", {31'd0, o_done}, 32'd1);
    inst_rd_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; inst_rd_en = 0; rd_en = 0; wr_en = 0; mem_signed = 0;
    inst_mem_addr = 0; data_mem_addr = 0; wr_data = 0; mem_byte_en = 0;
    slave_en = 1'b1; force_ack = 1'b0; waits = 0; s_iaddr = 32'hFFFF_FFF0; s_iword = 0; s_dword = 0;

    //   f  r  w  s  iaddr         iword         daddr         wdata         dword         be     nw inst          rd            busy stb we addr          sel     dato
    add(1, 0, 0, 0, 32'h100, 32'h0050_0093, 32'h000, 32'h0, 32'h0, 4'b0000, 0, 32'h0050_0093, 32'h0, 2, 1, 0, 32'h100, 4'b1111, 32'h0);
    add(1, 1, 0, 1, 32'h104, 32'h00A0_0113, 32'h203, 32'h0, 32'h80FF_0000, 4'b0001, 0, 32'h00A0_0113, 32'hFFFF_FF80, 3, 2, 0, 32'h200, 4'b1000, 32'h0);
    add(1, 0, 1, 0, 32'h108, 32'h0000_0213, 32'h302, 32'h1234, 32'h0, 4'b0011, 0, 32'h0000_0213, 32'hFFFF_FF80, 3, 2, 1, 32'h300, 4'b1100, 32'h1234_0000);
    add(1, 1, 0, 0, 32'h10C, 32'h1111_1111, 32'h202, 32'h0, 32'h80FF_0000, 4'b0011, 0, 32'h1111_1111, 32'h0000_80FF, 3, 2, 0, 32'h200, 4'b1100, 32'h0);
    add(1, 1, 0, 1, 32'h110, 32'h2222_2222, 32'h202, 32'h0, 32'h80FF_0000, 4'b0011, 0, 32'h2222_2222, 32'hFFFF_80FF, 3, 2, 0, 32'h200, 4'b1100, 32'h0);
    add(1, 1, 0, 1, 32'h114, 32'h3333_3333, 32'h200, 32'h0, 32'h80FF_0000, 4'b1111, 0, 32'h3333_3333, 32'h80FF_0000, 3, 2, 0, 32'h200, 4'b1111, 32'h0);
    add(1, 1, 0, 0, 32'h118, 32'h4444_4444, 32'h201, 32'h0, 32'h1234_5678, 4'b0001, 0, 32'h4444_4444, 32'h0000_0056, 3, 2, 0, 32'h200, 4'b0010, 32'h0);
    add(0, 0, 0, 0, 32'h000, 32'h0, 32'h000, 32'h0, 32'h0, 4'b0000, 0, 32'h4444_4444, 32'h0000_0056, 0, 0, 0, 32'h0, 4'b0000, 32'h0);
    add(1, 0, 0, 0, 32'h11C, 32'hDEAD_BEEF, 32'h000, 32'h0, 32'h0, 4'b0000, 3, 32'hDEAD_BEEF, 32'h0000_0056, 5, 4, 0, 32'h11C, 4'b1111, 32'h0);
    add(0, 1, 0, 1, 32'h000, 32'h0, 32'h200, 32'h0, 32'h0000_007F, 4'b0001, 0, 32'hDEAD_BEEF, 32'h0000_007F, 2, 1, 0, 32'h200, 4'b0001, 32'h0);
    add(1, 1, 0, 1, 32'h120, 32'h5555_5555, 32'h201, 32'h0, 32'h0000_8000, 4'b0001, 1, 32'h5555_5555, 32'hFFFF_FF80, 5, 4, 0, 32'h200, 4'b0010, 32'h0);
    add(0, 0, 1, 0, 32'h000, 32'h0, 32'h400, 32'hCAFE_F00D, 32'h0, 4'b1111, 0, 32'h5555_5555, 32'hFFFF_FF80, 2, 1, 1, 32'h400, 4'b1111, 32'hCAFE_F00D);
    add(1, 1, 1, 0, 32'h124, 32'h6666_6666, 32'h500, 32'hAB, 32'hFFFF_FFFF, 4'b0001, 0, 32'h6666_6666, 32'hFFFF_FF80, 3, 2, 1, 32'h500, 4'b0001, 32'h0000_00AB);

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_inst", inst, 32'h0000_0013);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_bus", {bus_cyc, bus_stb, bus_we, bus_sel, bus_addr[26:0]}, 32'h0);
    chk("reset_busy", {31'd0, mem_busy}, 32'd0);
    chk("reset_err", {31'd0, bus_err}, 32'd0);

    foreach (vecs[i]) begin
      do_step(vecs[i]);
      chk($sformatf("v%0d_busy", i), o_busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_stb", i), o_stb, vecs[i].exp_stb);
      chk($sformatf("v%0d_cyc", i), o_cyc, vecs[i].exp_stb);
      chk($sformatf("v%0d_we", i), o_we, vecs[i].exp_we);
      chk($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
      chk($sformatf("v%0d_inst_updates", i), o_ichg, {31'd0, vecs[i].f});
      chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, bus_err}, 32'd0);
      if (vecs[i].exp_stb > 0) begin
        chk($sformatf("v%0d_first_addr", i), o_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_first_sel", i), {28'd0, o_sel}, {28'd0, vecs[i].exp_sel});
        if (vecs[i].w) chk($sformatf("v%0d_dat_o", i), o_dato, vecs[i].exp_dato);
      end
    end

    // bus_ack outside a transaction must be ignored
    @(posedge clock); #1 force_ack = 1'b1;
    @(posedge clock); #1 force_ack = 1'b0;
    @(negedge clock);
    chk("idle_ack_inst", inst, 32'h6666_6666);
    chk("idle_ack_rd", rd_data, 32'hFFFF_FF80);
    chk("idle_ack_stb", {31'd0, bus_stb}, 32'd0);

`ifdef MEM_ARBITER_TIMEOUT_EN
    begin
      vec_t tv;
      tv = vecs[1];
      slave_en = 1'b0;
      do_step(tv);
      slave_en = 1'b1;
      chk("timeout_busy", o_busy, 32'd5);
      chk("timeout_stb", o_stb, 32'd4);
      chk("timeout_err", {31'd0, bus_err}, 32'd1);
      chk("timeout_rd", rd_data, 32'h0);
    end
`endif

    // Reset while a fetch is stalled on the bus
    slave_en = 1'b0;
    @(posedge clock); #1;
    inst_rd_en = 1'b1; inst_mem_addr = 32'h130; s_iaddr = 32'h130;
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_fetch_stb", {31'd0, bus_stb}, 32'd1);
    reset = 1'b1; inst_rd_en = 1'b0;
    @(negedge clock);
    chk("mid_reset_stb", {31'd0, bus_stb}, 32'd0);
    chk("mid_reset_cyc", {31'd0, bus_cyc}, 32'd0);
    chk("mid_reset_inst", inst, 32'h0000_0013);
    chk("mid_reset_rd", rd_data, 32'h0);
    chk("mid_reset_busy", {31'd0, mem_busy}, 32'd0);
    chk("mid_reset_err", {31'd0, bus_err}, 32'd0);
    reset = 1'b0;
    slave_en = 1'b1;
    do_step(vecs[0]);
    chk("post_reset_busy", o_busy, 32'd2);
    chk("post_reset_inst", inst, 32'h0050_0093);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle memory controller between the pipelined core (`dataflow`) and a single shared memory bus. Each pipeline step, it serializes the core's instruction fetch and optional data access onto one bus port, with the data access going first. It holds `mem_busy` high until every pending transaction has been acknowledged. It also aligns store data and byte enables to bus lanes, and aligns and sign- or zero-extends load data.

## Interface
Parameters:
- `DATA_SIZE`, 32: bus and core data width; 32 or 64.
- `TIMEOUT_CYCLES`, 255: ack watchdog limit. Used only with `MEM_ARBITER_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_rd_en` in 1: the core requests an instruction fetch this step.
- `inst_mem_addr` in DATA_SIZE: fetch address, 4-byte aligned.
- `inst` out 32: fetched instruction, held until the next fetch completes.
- `rd_en` in 1: load request.
- `wr_en` in 1: store request.
- `data_mem_addr` in DATA_SIZE: load/store byte address.
- `wr_data` in DATA_SIZE: store data, LSB-justified.
- `mem_byte_en` in DATA_SIZE/8: access size, unshifted, contiguous from bit 0.
- `mem_signed` in 1: sign-extend load result.
- `rd_data` out DATA_SIZE: aligned and extended load result, held until the next load completes.
- `mem_busy` out 1: pipeline stall request.
- `bus_cyc`, `bus_stb`, `bus_we` out 1 each: bus cycle, strobe and write flags.
- `bus_addr` out DATA_SIZE: word-aligned bus address.
- `bus_sel` out DATA_SIZE/8: lane select.
- `bus_dat_o` out DATA_SIZE: lane-aligned write data.
- `bus_dat_i` in DATA_SIZE: read data.
- `bus_ack` in 1: transaction acknowledge.
- `bus_err` out 1: timeout flag. Tied to 0 without the macro.

## Operation
States: `Idle`, `Data`, `Fetch`, `Done`.

**Idle**
- `mem_busy` is combinationally `inst_rd_en | rd_en | wr_en`.
- Go to `Data` if `rd_en | wr_en`.
- Otherwise go to `Fetch` if `inst_rd_en`.
- Otherwise stay in `Idle`.
- The core holds all request inputs stable while `mem_busy` = 1.

**Data**
- Drive `bus_cyc` = `bus_stb` = 1 and `bus_we` = `wr_en`.
- If both `wr_en` and `rd_en` are set, the access is a write.
- On `bus_ack`:
  - a load registers its result into `rd_data`;
  - go to `Fetch` if `inst_rd_en`, else to `Done`.

**Fetch**
- Drive `bus_cyc` = `bus_stb` = 1, `bus_we` = 0, `bus_addr` = `inst_mem_addr`, `bus_sel` = all ones.
- On `bus_ack`: `inst` <= the 32-bit word at lane `inst_mem_addr[2]` (64-bit), or `bus_dat_i` (32-bit); then go to `Done`.

**Done**
- `mem_busy` = 0 for exactly one cycle so the pipeline advances.
- Bus is idle. Go to `Idle` unconditionally.

**Alignment** (`off` = `data_mem_addr[log2(DATA_SIZE/8)-1:0]`)
- `bus_addr` = `data_mem_addr` with `off` bits cleared.
- `bus_sel` = `mem_byte_en << off`.
- `bus_dat_o` = `wr_data << 8*off`.
- Load result = `bus_dat_i >> 8*off`, masked to `popcount(mem_byte_en)` bytes.
  - With `mem_signed`, sign-extend from the top byte of the access.
  - Otherwise zero-extend.
- Misaligned accesses that cross a word boundary are undefined; exceptions are raised elsewhere.

**Boundary conditions**
- `bus_ack` is ignored in `Idle` and `Done`.
- Reset in any state forces `Idle` at the next edge; bus strobes drop that edge and any in-flight ack is lost.
- With no requests, the pipeline runs with `mem_busy` = 0 and no bus activity.

## Timing
- Reset values: `inst` = 0x00000013 (nop); `rd_data`, `bus_*` and `bus_err` = 0; state = `Idle`; `mem_busy` = 0 while no requests are pending.
- Bus outputs are registered, so strobes appear the cycle after a request is seen in `Idle`.
- Zero-wait slave, latency per pipeline step:
  - fetch only: 3 cycles (`Idle`, `Fetch`, `Done`);
  - fetch plus data: 4 cycles.
- Each wait state adds one cycle.
- `bus_stb` stays high, with address and data stable, until the `bus_ack` cycle. It deasserts at the following edge unless the next transaction follows back-to-back; between `Data` and `Fetch`, `bus_cyc` stays high.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - an 8+ bit counter resets on entry to `Data` or `Fetch`;
  - if `TIMEOUT_CYCLES` cycles pass without `bus_ack`, abort: drop strobes, set `bus_err` = 1 (sticky until reset), load 0 into the pending result, go to `Done`.
- Not defined: no counter; a missing ack stalls the core indefinitely; `bus_err` = 0.

## Test plan
- Reset, then `inst_rd_en` = 1 at address 0x100 with zero-wait slave returning 0x00500093 -> `bus_addr` = 0x100, `inst` = 0x00500093, `mem_busy` low in the third cycle only.
- Load byte, signed, `data_mem_addr` = 0x203, `bus_dat_i` = 0x80FF_0000 (32-bit) -> `bus_sel` = 4'b1000, `bus_addr` = 0x200, `rd_data` = 0xFFFF_FF80; the data transaction precedes the fetch.
- Store halfword at 0x302, `wr_data` = 0x1234 -> `bus_sel` = 4'b1100, `bus_dat_o` = 0x1234_0000, `bus_we` = 1 only during `Data`.
- Slave with 3 wait states on the fetch -> `bus_stb` held 4 cycles, `mem_busy` high for 5 cycles, `inst` updated once.
- Reset asserted during `Fetch` -> `Idle` next edge, strobes low, `inst` = 0x00000013.
- With the macro and `TIMEOUT_CYCLES` = 4, slave never acks -> abort after 4 cycles, `bus_err` = 1, `rd_data` = 0, `mem_busy` drops in `Done`.
